// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage: valid/ready request channel
// plus a response channel.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage and IF/ID register: one outstanding imem request and a one-entry response buffer.
// Define FETCH_PERF_EN to add the perf_fetched/perf_killed counters.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic [31:0]        PCTargetE,
    fetch_unit_if.master       imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               fetch_busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_killed
`endif
);

    typedef enum logic {ISSUE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc_inflight_reg, pc_inflight_next;
    logic        kill_reg, kill_next;
    logic        buf_valid_reg, buf_valid_next;
    logic [31:0] buf_instr_reg, buf_instr_next;
    logic [31:0] buf_pc_reg, buf_pc_next;
    logic [31:0] instr_d_reg, instr_d_next;
    logic [31:0] pc_d_reg, pc_d_next;
    logic [31:0] pc_plus4_d_reg, pc_plus4_d_next;

    logic req_valid;
    logic accept;
    logic rsp_in_wait;
    logic deliver;
    logic drop;
    logic bypass;

    // Issue is gated only by the buffer so a fetch-induced halt cannot deadlock.
    assign req_valid   = (state_reg == ISSUE) && !buf_valid_reg;
    assign accept      = req_valid && imem.imem_req_ready;
    assign rsp_in_wait = (state_reg == WAIT) && imem.imem_rsp_valid;
    assign deliver     = rsp_in_wait && !kill_reg && !FlushD;
    assign drop        = rsp_in_wait && (kill_reg || FlushD);
    assign bypass      = deliver && !StallD && !buf_valid_reg;

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc_reg;

    // Must stay independent of StallD: this feeds halt, which feeds StallD.
    assign fetch_busy = !(buf_valid_reg || (rsp_in_wait && !kill_reg)) && !FlushD;

    assign InstrD   = instr_d_reg;
    assign PCD      = pc_d_reg;
    assign PCPlus4D = pc_plus4_d_reg;

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        pc_inflight_next = pc_inflight_reg;
        kill_next        = kill_reg;
        buf_valid_next   = buf_valid_reg;
        buf_instr_next   = buf_instr_reg;
        buf_pc_next      = buf_pc_reg;
        instr_d_next     = instr_d_reg;
        pc_d_next        = pc_d_reg;
        pc_plus4_d_next  = pc_plus4_d_reg;

        case (state_reg)
            ISSUE: begin
                if (accept) begin
                    state_next       = WAIT;
                    pc_next          = pc_reg + 32'd4;
                    pc_inflight_next = pc_reg;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_next = ISSUE;
                    kill_next  = 1'b0;
                end
            end
            default: state_next = ISSUE;
        endcase

        if (deliver && !bypass) begin
            buf_valid_next = 1'b1;
            buf_instr_next = imem.imem_rsp_data;
            buf_pc_next    = pc_inflight_reg;
        end

        if (!StallD) begin
            if (buf_valid_reg) begin
                instr_d_next    = buf_instr_reg;
                pc_d_next       = buf_pc_reg;
                pc_plus4_d_next = buf_pc_reg + 32'd4;
                buf_valid_next  = 1'b0;
            end else if (bypass) begin
                instr_d_next    = imem.imem_rsp_data;
                pc_d_next       = pc_inflight_reg;
                pc_plus4_d_next = pc_inflight_reg + 32'd4;
            end else begin
                instr_d_next    = NOP_INSTR;
                pc_d_next       = 32'd0;
                pc_plus4_d_next = 32'd0;
            end
        end

        // Redirect wins over stall and over any response landing this cycle.
        if (FlushD) begin
            pc_next         = PCTargetE;
            buf_valid_next  = 1'b0;
            instr_d_next    = NOP_INSTR;
            pc_d_next       = 32'd0;
            pc_plus4_d_next = 32'd0;
            if (((state_reg == WAIT) && !imem.imem_rsp_valid) || accept)
                kill_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ISSUE;
            pc_reg          <= RESET_ADDR;
            pc_inflight_reg <= 32'd0;
            kill_reg        <= 1'b0;
            buf_valid_reg   <= 1'b0;
            buf_instr_reg   <= 32'd0;
            buf_pc_reg      <= 32'd0;
            instr_d_reg     <= NOP_INSTR;
            pc_d_reg        <= 32'd0;
            pc_plus4_d_reg  <= 32'd0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            pc_inflight_reg <= pc_inflight_next;
            kill_reg        <= kill_next;
            buf_valid_reg   <= buf_valid_next;
            buf_instr_reg   <= buf_instr_next;
            buf_pc_reg      <= buf_pc_next;
            instr_d_reg     <= instr_d_next;
            pc_d_reg        <= pc_d_next;
            pc_plus4_d_reg  <= pc_plus4_d_next;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_killed_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_fetched_reg <= 32'd0;
            perf_killed_reg  <= 32'd0;
        end else begin
            if (deliver)
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (drop)
                perf_killed_reg <= perf_killed_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_killed  = perf_killed_reg;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the kianv 5-stage core.
- Consumes the decode stall, decode flush and branch-redirect controls that the hazard logic produces.
- Drives a valid/ready instruction-memory port with one outstanding request and a one-entry response buffer.
- Returns `fetch_busy`, which the core ORs into the pipeline `halt`, closing the stall loop from the fetch side.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble injected into decode (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- StallD  in  1  hold IF/ID register and response buffer.
- FlushD  in  1  redirect; already qualified by !halt upstream.
- PCTargetE  in  32  redirect target, sampled when FlushD=1.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  request address, equals PCF.
- imem_rsp_valid  in  1  response valid; at most one per accepted request, earliest 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- fetch_busy  out  1  no instruction available for decode this cycle; goes to halt.

Behaviour:
Reset values:
- PCF=RESET_ADDR, state=ISSUE, buf_valid=0, kill=0.
- InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
- Reset asserted mid-transaction abandons the outstanding request. Responses arriving in ISSUE are ignored.

FSM:
- ISSUE: imem_req_valid=1 only when buf_valid=0. On valid&ready, go to WAIT and set PCF<=PCF+4 (32-bit wrap, 32'hFFFF_FFFC+4=0). Latch issued PC into pc_inflight.
- WAIT: imem_req_valid=0. On imem_rsp_valid:
  - If kill=1: drop the data, clear kill, go to ISSUE.
  - Otherwise deliver {data, pc_inflight}, go to ISSUE.

Delivery:
- Bypass: if StallD=0 and buf_valid=0, the response loads IF/ID directly.
- Otherwise it is written to the buffer, buf_valid<=1.

IF/ID update, when StallD=0:
- FlushD=1: load NOP_INSTR, PCD=0.
- Else if buf_valid=1: load the buffer, clear buf_valid.
- Else if bypass response present: load the response.
- Else: load NOP_INSTR, PCD=0.
- PCPlus4D = PCD+4, registered alongside PCD; 0 for bubbles.
- StallD=1 holds IF/ID and buffer unchanged, unless FlushD=1.

Redirect (FlushD=1), overrides everything:
- PCF<=PCTargetE; buf_valid<=0.
- If state=WAIT and no response this cycle, set kill=1.
- If the response arrives in the same cycle, it is dropped and state goes to ISSUE.
- A request accepted in the same cycle as FlushD is killed (kill=1) and PCF<=PCTargetE.
- FlushD has priority over StallD.

fetch_busy:
- Definition: !(buf_valid | (state==WAIT & imem_rsp_valid & !kill)) & !FlushD.
- Combinational from state and memory inputs only. It must never depend on StallD, to avoid a loop through halt.
- The issue path is gated only by buf_valid, never by the stall inputs, so a fetch-induced halt cannot deadlock.

Throughput: one instruction per 2 cycles with a 1-cycle memory.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetched[31:0] and perf_killed[31:0].
  - perf_fetched increments on every delivered response.
  - perf_killed increments on every dropped response.
  - Both reset to 0 and wrap at 2^32.
- Undefined: no counters and no counter ports; all other behaviour identical.

Test Plan:
- Reset, RESET_ADDR=0, 1-cycle memory returning addr|32'h100 → imem_addr 0,4,8 in order; InstrD sequence 32'h100,32'h104,32'h108 with matching PCD; PCPlus4D=PCD+4.
- StallD held 4 cycles while a response arrives → response buffered, no new request while buf_valid=1, InstrD unchanged; after release, the buffered instruction enters decode, then the next fetch issues.
- FlushD with PCTargetE=32'h80 while in WAIT, response arriving 2 cycles later → response dropped, InstrD=NOP_INSTR, next imem_addr=32'h80 (with FETCH_PERF_EN: perf_killed=1).
- FlushD in the same cycle as imem_rsp_valid, StallD=1 → FlushD wins: InstrD=NOP_INSTR, PCD=0, response not delivered, next address=PCTargetE.
- imem_req_ready low for 5 cycles → imem_req_valid stays 1 with a stable address, fetch_busy=1 throughout, InstrD=NOP_INSTR; resetn pulse during WAIT → all outputs return to reset values and a later stale rsp_valid is ignored.
- PCF=32'hFFFF_FFFC accepted → next imem_addr=32'h0000_0000.
